// File: rtl/dbg_pkg.sv
// dbg_pkg: shared types for the debug trace buffer.
//   dbg_rec_t   - one retired-instruction record (packed, REC_W bits, pc in the MSBs)
//   dbg_state_e - capture state machine encoding, visible on the top-level state port
//   REC_W       - width of a packed record
//   PC_LSB      - bit position of the pc field LSB inside a packed record
package dbg_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wd;
    logic        regwrite;
  } dbg_rec_t;

  localparam int REC_W  = 142;
  localparam int PC_LSB = REC_W - 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_FROZEN  = 2'd3
  } dbg_state_e;

endpackage

// File: rtl/dbg_trace_ram.sv
// dbg_trace_ram: DEPTH x W record storage.
//   clk   - clock
//   we    - write enable, write lands on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, asynchronous (combinational from raddr)
// Contents are intentionally not reset.
module dbg_trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 142,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dbg_trace_buffer.sv
// dbg_trace_buffer: circular trace of retired-instruction records with
// arm/stop control, PC-match trigger and post-trigger capture window.
//   clk, reset        - clock, synchronous active-high reset
//   cap_valid/cap_rec - record presented for capture
//   arm               - pulse: clear buffer and start capturing
//   stop              - pulse: freeze capture
//   trig_en/trig_pc   - PC-match trigger enable and PC
//   rd_valid/rd_ready - readout handshake, oldest record first
//   rd_rec            - oldest record (combinational from rd_ptr)
//   count             - entries held
//   state             - current dbg_state_e
//   overflow          - sticky, a record was lost or overwritten
//   triggered         - sticky, the trigger fired
// Readout is only offered in IDLE/FROZEN so capture and drain never overlap.
module dbg_trace_buffer
  import dbg_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WRAP      = 1,
  parameter int POST_TRIG = 4,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap_valid,
  input  logic [REC_W-1:0] cap_rec,
  input  logic             arm,
  input  logic             stop,
  input  logic             trig_en,
  input  logic [31:0]      trig_pc,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [REC_W-1:0] rd_rec,
  output logic [CW-1:0]    count,
  output logic [1:0]       state,
  output logic             overflow,
  output logic             triggered
);

  dbg_state_e    st;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] post_cnt;

  logic capturing, full, wr_en, drop, pop, trig_hit, rd_side;

  assign capturing = (st == ST_CAPTURE) || (st == ST_POST);
  assign full      = (count == CW'(DEPTH));

  // Full with WRAP=0 discards the new record; with WRAP=1 it overwrites
  // the oldest one and the read pointer follows the write pointer.
  assign wr_en = capturing && cap_valid && !arm && !reset && (!full || (WRAP != 0));
  assign drop  = capturing && cap_valid && full && (WRAP == 0);

  // Only CAPTURE arms the comparator, so matches during POST are ignored.
  assign trig_hit = (st == ST_CAPTURE) && trig_en && cap_valid &&
                    (cap_rec[REC_W-1:PC_LSB] == trig_pc);

  assign rd_side  = (st == ST_IDLE) || (st == ST_FROZEN);
  assign rd_valid = rd_side && (count != '0);
  assign pop      = rd_valid && rd_ready;
  assign state    = st;

  dbg_trace_ram #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (cap_rec),
    .raddr (rd_ptr),
    .rdata (rd_rec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
    end else if (arm) begin
      // arm outranks stop, trigger and pop in every state
      st        <= ST_CAPTURE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
    end else begin
      // write side (only active in CAPTURE/POST)
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (full) begin
          rd_ptr   <= rd_ptr + 1'b1;
          overflow <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else if (drop) begin
        overflow <= 1'b1;
      end

      // read side (only active in IDLE/FROZEN, never overlaps a write)
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end

      case (st)
        ST_CAPTURE: begin
          if (trig_hit) begin
            triggered <= 1'b1;
            post_cnt  <= AW'(POST_TRIG);
          end
          if (stop || (trig_hit && POST_TRIG == 0)) st <= ST_FROZEN;
          else if (trig_hit)                         st <= ST_POST;
        end
        ST_POST: begin
          // the record that takes the counter to zero is the last one stored
          if (cap_valid) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == AW'(1)) st <= ST_FROZEN;
          end
          if (stop) st <= ST_FROZEN;
        end
        default: ; // IDLE and FROZEN only leave on arm/reset
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_trace_buffer.sv
module tb_dbg_trace_buffer;
  import dbg_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset, cap_valid, arm, stop, trig_en, rd_ready;
  logic [REC_W-1:0] cap_rec;
  logic [31:0]      trig_pc;

  // u_w: WRAP=1, u_d: WRAP=0; both share every input
  logic             w_rd_valid, w_overflow, w_triggered;
  logic [REC_W-1:0] w_rd_rec;
  logic [CW-1:0]    w_count;
  logic [1:0]       w_state;
  logic             d_rd_valid, d_overflow, d_triggered;
  logic [REC_W-1:0] d_rd_rec;
  logic [CW-1:0]    d_count;
  logic [1:0]       d_state;

  dbg_rec_t w_view, d_view;
  assign w_view = w_rd_rec;
  assign d_view = d_rd_rec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbg_trace_buffer #(.DEPTH(DEPTH), .WRAP(1), .POST_TRIG(4)) u_w (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_rec(cap_rec),
    .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_valid(w_rd_valid), .rd_ready(rd_ready), .rd_rec(w_rd_rec),
    .count(w_count), .state(w_state), .overflow(w_overflow), .triggered(w_triggered)
  );

  dbg_trace_buffer #(.DEPTH(DEPTH), .WRAP(0), .POST_TRIG(4)) u_d (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_rec(cap_rec),
    .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_valid(d_rd_valid), .rd_ready(rd_ready), .rd_rec(d_rd_rec),
    .count(d_count), .state(d_state), .overflow(d_overflow), .triggered(d_triggered)
  );

  function automatic dbg_rec_t mk_rec(input logic [31:0] pc);
    dbg_rec_t r;
    r.pc        = pc;
    r.op        = 7'h13;
    r.rd        = pc[6:2];
    r.result    = ~pc;
    r.dmem_we   = pc[2];
    r.dmem_addr = pc + 32'h1000;
    r.dmem_wd   = pc ^ 32'hA5A5_A5A5;
    r.regwrite  = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    reset = 0; cap_valid = 0; arm = 0; stop = 0; rd_ready = 0;
    cap_rec = mk_rec(32'h0);
  endtask

  // one cycle with the current inputs, then settle past the edge
  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic cap(input logic [31:0] pc);
    cap_valid = 1; cap_rec = mk_rec(pc);
    step();
  endtask

  typedef struct {
    logic        arm, stop, cv, rr;
    logic [31:0] pc;
    logic [1:0]  st;
    int          cnt;
    logic        rv;
    logic [31:0] rpc;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // basic capture / stop / drain, expectations are post-edge
    tbl[0]  = '{arm:1, stop:0, cv:0, rr:0, pc:32'h0,  st:2'd1, cnt:0, rv:0, rpc:32'h0};
    tbl[1]  = '{arm:0, stop:0, cv:1, rr:0, pc:32'h0,  st:2'd1, cnt:1, rv:0, rpc:32'h0};
    tbl[2]  = '{arm:0, stop:0, cv:1, rr:0, pc:32'h4,  st:2'd1, cnt:2, rv:0, rpc:32'h0};
    tbl[3]  = '{arm:0, stop:0, cv:1, rr:0, pc:32'h8,  st:2'd1, cnt:3, rv:0, rpc:32'h0};
    tbl[4]  = '{arm:0, stop:0, cv:1, rr:0, pc:32'hC,  st:2'd1, cnt:4, rv:0, rpc:32'h0};
    tbl[5]  = '{arm:0, stop:0, cv:1, rr:0, pc:32'h10, st:2'd1, cnt:5, rv:0, rpc:32'h0};
    tbl[6]  = '{arm:0, stop:1, cv:0, rr:0, pc:32'h0,  st:2'd3, cnt:5, rv:1, rpc:32'h0};
    tbl[7]  = '{arm:0, stop:0, cv:0, rr:1, pc:32'h0,  st:2'd3, cnt:4, rv:1, rpc:32'h4};
    tbl[8]  = '{arm:0, stop:0, cv:0, rr:1, pc:32'h0,  st:2'd3, cnt:3, rv:1, rpc:32'h8};
    tbl[9]  = '{arm:0, stop:0, cv:0, rr:1, pc:32'h0,  st:2'd3, cnt:2, rv:1, rpc:32'hC};
    tbl[10] = '{arm:0, stop:0, cv:0, rr:1, pc:32'h0,  st:2'd3, cnt:1, rv:1, rpc:32'h10};
    tbl[11] = '{arm:0, stop:0, cv:0, rr:1, pc:32'h0,  st:2'd3, cnt:0, rv:0, rpc:32'h0};
    // record presented while FROZEN must be ignored
    tbl[12] = '{arm:0, stop:0, cv:1, rr:0, pc:32'h99, st:2'd3, cnt:0, rv:0, rpc:32'h0};

    idle_in();
    trig_en = 0; trig_pc = 32'h0;
    reset = 1;
    step(); reset = 1; step();

    chk("reset_state", 32'(w_state), 32'd0);
    chk("reset_count", 32'(w_count), 32'd0);
    chk("reset_rd_valid", 32'(w_rd_valid), 32'd0);
    chk("reset_overflow", 32'(w_overflow), 32'd0);
    chk("reset_triggered", 32'(w_triggered), 32'd0);

    for (int i = 0; i < 13; i++) begin
      arm = tbl[i].arm; stop = tbl[i].stop; rd_ready = tbl[i].rr;
      cap_valid = tbl[i].cv; cap_rec = mk_rec(tbl[i].pc);
      step();
      chk($sformatf("tbl%0d_state_w", i), 32'(w_state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_count_w", i), 32'(w_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_rdv_w", i), 32'(w_rd_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_count_d", i), 32'(d_count), 32'(tbl[i].cnt));
      if (tbl[i].rv) begin
        chk($sformatf("tbl%0d_pc_w", i), w_view.pc, tbl[i].rpc);
        chk($sformatf("tbl%0d_res_w", i), w_view.result, ~tbl[i].rpc);
        chk($sformatf("tbl%0d_pc_d", i), d_view.pc, tbl[i].rpc);
      end
    end

    // 20 records into a 16-deep buffer: wrap vs drop
    arm = 1; step();
    for (int i = 0; i < 20; i++) cap(32'(4 * i));
    stop = 1; step();
    chk("wrap_overflow", 32'(w_overflow), 32'd1);
    chk("wrap_count", 32'(w_count), 32'd16);
    chk("drop_overflow", 32'(d_overflow), 32'd1);
    chk("drop_count", 32'(d_count), 32'd16);
    step();  // rd_ready low: head must stay put
    chk("hold_pc_w", w_view.pc, 32'h10);
    chk("hold_pc_d", d_view.pc, 32'h0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("wrap_pop%0d", k), w_view.pc, 32'(32'h10 + 4 * k));
      chk($sformatf("drop_pop%0d", k), d_view.pc, 32'(4 * k));
      rd_ready = 1; step();
    end
    chk("drain_rdv_w", 32'(w_rd_valid), 32'd0);
    chk("drain_rdv_d", 32'(d_rd_valid), 32'd0);
    chk("drain_state_w", 32'(w_state), 32'd3);

    // trigger at pc 0x40 with 4 post records
    trig_en = 1; trig_pc = 32'h40;
    arm = 1; step();
    for (int i = 0; i < 25; i++) begin
      cap(32'(4 * i));
      if (i == 15) chk("pre_trig_state", 32'(w_state), 32'd1);
      if (i == 16) begin
        chk("trig_fired", 32'(w_triggered), 32'd1);
        chk("trig_post_state", 32'(w_state), 32'd2);
      end
      if (i == 19) chk("post_state_19", 32'(w_state), 32'd2);
      if (i == 20) chk("frozen_after_0x50", 32'(w_state), 32'd3);
    end
    chk("trig_count", 32'(w_count), 32'd16);
    chk("trig_sticky", 32'(w_triggered), 32'd1);
    chk("trig_head_pc", w_view.pc, 32'h14);

    // arm beats stop and a same-cycle trigger match (from FROZEN, then CAPTURE)
    for (int r = 0; r < 2; r++) begin
      arm = 1; stop = 1; cap_valid = 1; cap_rec = mk_rec(32'h40);
      step();
      chk($sformatf("arm_prio%0d_state", r), 32'(w_state), 32'd1);
      chk($sformatf("arm_prio%0d_count", r), 32'(w_count), 32'd0);
      chk($sformatf("arm_prio%0d_trig", r), 32'(w_triggered), 32'd0);
      chk($sformatf("arm_prio%0d_ovf", r), 32'(w_overflow), 32'd0);
    end

    // reset while in POST with 9 entries
    trig_pc = 32'h20;
    arm = 1; step();
    for (int i = 0; i < 9; i++) cap(32'(4 * i));
    chk("post9_state", 32'(w_state), 32'd2);
    chk("post9_count", 32'(w_count), 32'd9);
    reset = 1; step();
    chk("rst_post_state", 32'(w_state), 32'd0);
    chk("rst_post_count", 32'(w_count), 32'd0);
    chk("rst_post_rdv", 32'(w_rd_valid), 32'd0);
    chk("rst_post_trig", 32'(w_triggered), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_trace_buffer.md
DBG_TRACE_BUFFER -- requirements
Module: dbg_trace_buffer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DEPTH, 16, number of trace entries; power of two, >= 4.
- WRAP, 1, 1 = overwrite oldest when full; 0 = drop new records when full.
- POST_TRIG, 4, records captured after the trigger record before freezing; 0..DEPTH-1.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, the single clock.
- reset, in, 1, synchronous, active-high.
- cap_valid, in, 1, a retired-instruction record is presented this cycle.
- cap_rec, in, REC_W, packed dbg_rec_t record.
- arm, in, 1, pulse: clear buffer, start capture.
- stop, in, 1, pulse: freeze capture.
- trig_en, in, 1, enable PC-match trigger.
- trig_pc, in, 32, trigger PC.
- rd_valid, out, 1, oldest record is available.
- rd_ready, in, 1, consumer accepts the record.
- rd_rec, out, REC_W, oldest record.
- count, out, $clog2(DEPTH)+1, entries held.
- state, out, 2, current dbg_state_e.
- overflow, out, 1, sticky; a record was lost or overwritten.
- triggered, out, 1, sticky; the trigger fired.

Function
REQ-003 States SHALL be IDLE=0, CAPTURE=1, POST=2, FROZEN=3.
REQ-004 arm in any state SHALL, at the next edge, zero the pointers, count, overflow and triggered, and enter CAPTURE; arm SHALL win over simultaneous stop, trigger or pop.
REQ-005 In IDLE and FROZEN, cap_valid SHALL be ignored.
REQ-006 In CAPTURE/POST, cap_valid SHALL write cap_rec at wr_ptr on the same edge; wr_ptr SHALL increment modulo DEPTH.
REQ-007 When full with WRAP=1: write SHALL proceed, rd_ptr SHALL advance, count SHALL hold, overflow SHALL set.
REQ-008 When full with WRAP=0: the record SHALL be dropped, pointers SHALL hold, overflow SHALL set.
REQ-009 Trigger: in CAPTURE with trig_en and cap_valid and cap_rec.pc==trig_pc, the record SHALL be written, triggered SHALL set, and the post counter SHALL load POST_TRIG.
REQ-010 After a trigger, the next state SHALL be FROZEN if POST_TRIG==0, else POST.
REQ-011 In POST, each accepted cap_valid SHALL decrement the post counter; the write that brings it to 0 SHALL be stored, and the block SHALL then enter FROZEN.
REQ-012 In POST, further PC matches SHALL be ignored.
REQ-013 stop in CAPTURE/POST SHALL enter FROZEN next edge; a record presented the same cycle SHALL still be written.
REQ-014 rd_valid SHALL equal (state==IDLE or FROZEN) and count!=0.
REQ-015 rd_rec SHALL combinationally show the entry at rd_ptr.
REQ-016 A pop (rd_valid and rd_ready) SHALL increment rd_ptr modulo DEPTH and decrement count.
REQ-017 rd_rec SHALL be held stable while rd_valid=1 and rd_ready=0.
REQ-018 FROZEN SHALL persist until arm or reset, including after the buffer drains.
REQ-019 A record written at edge t SHALL be readable no earlier than the cycle after freezing; capture-to-readout order SHALL be oldest first.

Reset
REQ-020 Reset SHALL force: state IDLE, pointers and count 0, post counter 0, overflow 0, triggered 0, rd_valid 0.
REQ-021 Reset mid-capture or mid-readout SHALL discard all entries; RAM contents SHALL not be reset.

Structure
REQ-022 dbg_pkg SHALL hold:
- dbg_rec_t packed: pc 32, op 7, rd 5, result 32, dmem_we 1, dmem_addr 32, dmem_wd 32, regwrite 1.
- REC_W = 142.
- dbg_state_e.
REQ-023 Storage SHALL be a sub-module dbg_trace_ram: DEPTH x REC_W, one synchronous write port, one asynchronous read port.

Verification
REQ-024 Directed scenarios the bench SHALL cover:
- arm, 5 records pc=0x0,0x4,..,0x10, stop -> FROZEN, count=5; pops return pcs 0x0..0x10 in order; then rd_valid=0, state stays 3.
- WRAP=1, DEPTH=16, 20 records pc=4*i -> overflow=1, count=16; first pop pc=0x10.
- WRAP=0, 20 records -> overflow=1, count=16; first pop pc=0x0, last pop pc=0x3C.
- trig_pc=0x40, POST_TRIG=4, records pc=4*i -> FROZEN after pc=0x50 is written; triggered=1; later records ignored; count=16.
- arm asserted with stop and a trigger match in the same cycle -> CAPTURE, count=0, triggered=0.
- reset during POST with count=9 -> IDLE, count=0, rd_valid=0.
